// File: rtl/dma_engine_if.sv
// dma_engine_if: bundles the core-side DMA command/status signals, the DRAM
// request/ack port and the SRAM port of dma_engine.
//   master : view taken by dma_engine (drives stall/status, DRAM and SRAM requests)
//   slave  : view taken by the core/memory side (drives commands, acks, read data)
// Signal names match the original dma_engine ports.
interface dma_engine_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WIDTH_W = 10
);
    logic [1:0]         dmaCmd;
    logic [ADDR_W-1:0]  dmaSrcAddress;
    logic [ADDR_W-1:0]  dmaDstAddress;
    logic [WIDTH_W-1:0] dmaWidth;
    logic               stall;
    logic               dmaValid;
    logic               dmaErr;
    logic               dramReq;
    logic               dramWe;
    logic [ADDR_W-1:0]  dramAddress;
    logic [31:0]        dramWriteData;
    logic               dramAck;
    logic [31:0]        dramReadData;
    logic [ADDR_W-1:0]  sramAddress;
    logic               sramWe;
    logic [31:0]        sramWriteData;
    logic [31:0]        sramReadData;

    modport master (
        input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        input  dramAck, dramReadData, sramReadData,
        output stall, dmaValid, dmaErr,
        output dramReq, dramWe, dramAddress, dramWriteData,
        output sramAddress, sramWe, sramWriteData
    );

    modport slave (
        output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        output dramAck, dramReadData, sramReadData,
        input  stall, dmaValid, dmaErr,
        input  dramReq, dramWe, dramAddress, dramWriteData,
        input  sramAddress, sramWe, sramWriteData
    );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: word-copy DMA responder beside the core.
//   dmaCmd 01 copies DRAM->SRAM (d2s), 10 copies SRAM->DRAM (s2d); 00/11 ignored.
//   stall is held while a copy runs; dmaValid pulses one cycle on completion.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - dma_engine_if.master: command/status, DRAM req/ack, SRAM port
// Optional feature macro DMA_ALIGN_CHECK_EN:
//   defined   - misaligned src/dst completes immediately with dmaErr=1
//   undefined - address bits [1:0] are cleared when the command is latched
// All outputs are registered.
module dma_engine #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WIDTH_W = 10
) (
    input  logic         clk,
    input  logic         reset,
    dma_engine_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic               is_s2d_q, is_s2d_d;
    logic               phase_q, phase_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [WIDTH_W-1:0] rem_q, rem_d;

    logic               stall_q, stall_d;
    logic               dma_valid_q, dma_valid_d;
    logic               dma_err_q, dma_err_d;
    logic               dram_req_q, dram_req_d;
    logic               dram_we_q, dram_we_d;
    logic [ADDR_W-1:0]  dram_addr_q, dram_addr_d;
    logic [31:0]        dram_wdata_q, dram_wdata_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic               sram_we_q, sram_we_d;
    logic [31:0]        sram_wdata_q, sram_wdata_d;

    logic [ADDR_W-1:0]  src_in, dst_in;
    logic               misaligned;
    logic               issue_rd;
    logic [ADDR_W-1:0]  issue_addr;

`ifdef DMA_ALIGN_CHECK_EN
    assign misaligned = (bus.dmaSrcAddress[1:0] != 2'b00) || (bus.dmaDstAddress[1:0] != 2'b00);
    assign src_in     = bus.dmaSrcAddress;
    assign dst_in     = bus.dmaDstAddress;
`else
    assign misaligned = 1'b0;
    assign src_in     = bus.dmaSrcAddress & ~ADDR_W'(3);
    assign dst_in     = bus.dmaDstAddress & ~ADDR_W'(3);
`endif

    always_comb begin
        state_d      = state_q;
        is_s2d_d     = is_s2d_q;
        phase_d      = phase_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        stall_d      = stall_q;
        dma_valid_d  = 1'b0;
        dma_err_d    = dma_err_q;
        dram_req_d   = dram_req_q;
        dram_we_d    = dram_we_q;
        dram_addr_d  = dram_addr_q;
        dram_wdata_d = dram_wdata_q;
        sram_addr_d  = '0;
        sram_we_d    = 1'b0;
        sram_wdata_d = '0;
        issue_rd     = 1'b0;
        issue_addr   = src_q;

        unique case (state_q)
            IDLE: begin
                if (bus.dmaCmd == 2'b01 || bus.dmaCmd == 2'b10) begin
                    is_s2d_d  = bus.dmaCmd[1];
                    src_d     = src_in;
                    dst_d     = dst_in;
                    rem_d     = bus.dmaWidth;
                    stall_d   = 1'b1;
                    dma_err_d = misaligned;
                    if (misaligned || bus.dmaWidth == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RD;
                        issue_rd   = 1'b1;
                        issue_addr = src_in;
                    end
                end
            end
            RD: begin
                if (is_s2d_q) begin
                    // phase 0: SRAM address on the port; phase 1: read data valid
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        state_d      = WR;
                        dram_req_d   = 1'b1;
                        dram_we_d    = 1'b1;
                        dram_addr_d  = dst_q;
                        dram_wdata_d = bus.sramReadData;
                    end
                end else if (bus.dramAck) begin
                    state_d      = WR;
                    dram_req_d   = 1'b0;
                    dram_addr_d  = '0;
                    sram_we_d    = 1'b1;
                    sram_addr_d  = dst_q;
                    sram_wdata_d = bus.dramReadData;
                end
            end
            WR: begin
                // SRAM write (d2s) always finishes in its single cycle
                if (!is_s2d_q || bus.dramAck) begin
                    dram_req_d   = 1'b0;
                    dram_we_d    = 1'b0;
                    dram_addr_d  = '0;
                    dram_wdata_d = '0;
                    src_d        = src_q + ADDR_W'(4);
                    dst_d        = dst_q + ADDR_W'(4);
                    rem_d        = rem_q - WIDTH_W'(1);
                    if (rem_q == WIDTH_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d    = RD;
                        issue_rd   = 1'b1;
                        issue_addr = src_q + ADDR_W'(4);
                    end
                end
            end
            DONE: begin
                stall_d     = 1'b0;
                dma_valid_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        // Read outputs are registered, so they are launched on entry to RD.
        if (issue_rd) begin
            phase_d = 1'b0;
            if (is_s2d_d) begin
                sram_addr_d = issue_addr;
            end else begin
                dram_req_d  = 1'b1;
                dram_we_d   = 1'b0;
                dram_addr_d = issue_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            is_s2d_q     <= 1'b0;
            phase_q      <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            stall_q      <= 1'b0;
            dma_valid_q  <= 1'b0;
            dma_err_q    <= 1'b0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            sram_addr_q  <= '0;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            is_s2d_q     <= is_s2d_d;
            phase_q      <= phase_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            stall_q      <= stall_d;
            dma_valid_q  <= dma_valid_d;
            dma_err_q    <= dma_err_d;
            dram_req_q   <= dram_req_d;
            dram_we_q    <= dram_we_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign bus.stall         = stall_q;
    assign bus.dmaValid      = dma_valid_q;
    assign bus.dmaErr        = dma_err_q;
    assign bus.dramReq       = dram_req_q;
    assign bus.dramWe        = dram_we_q;
    assign bus.dramAddress   = dram_addr_q;
    assign bus.dramWriteData = dram_wdata_q;
    assign bus.sramAddress   = sram_addr_q;
    assign bus.sramWe        = sram_we_q;
    assign bus.sramWriteData = sram_wdata_q;
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: scoreboard bench for dma_engine with DRAM/SRAM models.
module tb_dma_engine;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WIDTH_W    = 10;
    localparam int          CYC_BUDGET = 20000;
    localparam int EV_DRD = 0, EV_SWR = 1, EV_DWR = 2, EV_DONE = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   lat_min  = 0;
    int   lat_max  = 0;
    ev_t  exp_q[$];
    logic [31:0] dram_mem [bit [31:0]];
    logic [31:0] sram_mem [bit [31:0]];

    dma_engine_if #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) bus ();

    dma_engine #(.ADDR_W(ADDR_W), .WIDTH_W(WIDTH_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dram_peek(input logic [31:0] a);
        if (dram_mem.exists(a)) return dram_mem[a];
        return a ^ 32'h5EED_0000;
    endfunction

    function automatic logic [31:0] sram_peek(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the full list of externally visible events of one command.
    task automatic push_expected(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                                 input logic [9:0] w);
        logic [31:0] a, b;
        if (c != 2'b01 && c != 2'b10) return;
`ifdef DMA_ALIGN_CHECK_EN
        if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
            exp_q.push_back('{EV_DONE, 32'h0, 32'h1});
            return;
        end
`else
        s[1:0] = 2'b00;
        d[1:0] = 2'b00;
`endif
        for (int unsigned i = 0; i < w; i++) begin
            a = s + 32'(4 * i);
            b = d + 32'(4 * i);
            if (c == 2'b01) begin
                exp_q.push_back('{EV_DRD, a, 32'h0});
                exp_q.push_back('{EV_SWR, b, dram_peek(a)});
            end else begin
                exp_q.push_back('{EV_DWR, b, sram_peek(a)});
            end
        end
        exp_q.push_back('{EV_DONE, 32'h0, 32'h0});
    endtask

    task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] dt);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got kind=%0d addr=0x%h data=0x%h expected no event", k, a, dt);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.addr !== a || e.data !== dt) begin
            failures++;
            $display("FAIL sb_event: got kind=%0d addr=0x%h data=0x%h expected kind=%0d addr=0x%h data=0x%h",
                     k, a, dt, e.kind, e.addr, e.data);
        end
    endtask

    // DRAM responder: acks each request after lat cycles (lat chosen per request).
    initial begin
        int cnt, lat;
        bit busy;
        bus.dramAck = 1'b0;
        bus.dramReadData = '0;
        busy = 0; cnt = 0; lat = 0;
        forever begin
            @(negedge clk);
            bus.dramAck = 1'b0;
            if (reset && bus.dramReq) begin
                if (!busy) begin
                    busy = 1;
                    cnt = 0;
                    lat = $urandom_range(lat_max, lat_min);
                end
                if (cnt >= lat) begin
                    bus.dramAck = 1'b1;
                    if (bus.dramWe) dram_mem[bus.dramAddress] = bus.dramWriteData;
                    else bus.dramReadData = dram_peek(bus.dramAddress);
                    busy = 0;
                end else begin
                    cnt++;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // SRAM model: read data appears the cycle after the address.
    initial begin
        logic [31:0] prev_addr;
        prev_addr = '0;
        bus.sramReadData = '0;
        forever begin
            @(negedge clk);
            bus.sramReadData = sram_peek(prev_addr);
            prev_addr = bus.sramAddress;
            if (reset && bus.sramWe) sram_mem[bus.sramAddress] = bus.sramWriteData;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a visible event.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (bus.dramReq && bus.dramAck) begin
                    if (bus.dramWe) expect_ev(EV_DWR, bus.dramAddress, bus.dramWriteData);
                    else expect_ev(EV_DRD, bus.dramAddress, 32'h0);
                end
                if (bus.sramWe) expect_ev(EV_SWR, bus.sramAddress, bus.sramWriteData);
                if (bus.dmaValid) begin
                    expect_ev(EV_DONE, 32'h0, {31'b0, bus.dmaErr});
                    check_eq("stall_at_valid", 64'(bus.stall), 64'd0);
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                           input logic [9:0] w, input int exp_lat);
        int cyc, stall_drops;
        bit seen, timed_out;
        push_expected(c, s, d, w);
        @(negedge clk);
        bus.dmaCmd = c;
        bus.dmaSrcAddress = s;
        bus.dmaDstAddress = d;
        bus.dmaWidth = w;
        @(negedge clk);
        bus.dmaCmd = 2'b00;
        cyc = 1; stall_drops = 0; seen = 0; timed_out = 0;
        while (!seen && !timed_out) begin
            #2;
            if (bus.dmaValid) begin
                seen = 1;
            end else begin
                if (!bus.stall) stall_drops++;
                if (cyc >= CYC_BUDGET) begin
                    timed_out = 1;
                    checks++; failures++;
                    $display("FAIL done_timeout: no dmaValid after %0d cycles, required within %0d", cyc, CYC_BUDGET);
                end else begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        check_eq("stall_busy_drops", 64'(stall_drops), 64'd0);
        if (exp_lat >= 0 && !timed_out) check_eq("valid_latency", 64'(cyc), 64'(exp_lat));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  c;
        logic [31:0] s, d;
        logic [9:0]  w;
        int idle_busy;
        bit found;

        reset = 1'b0;
        bus.dmaCmd = 2'b00;
        bus.dmaSrcAddress = '0;
        bus.dmaDstAddress = '0;
        bus.dmaWidth = '0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("reset_ctrl", 64'({bus.stall, bus.dmaValid, bus.dmaErr, bus.dramReq, bus.dramWe, bus.sramWe}), 64'd0);
        check_eq("reset_bus", 64'(bus.dramAddress | bus.dramWriteData | bus.sramAddress | bus.sramWriteData), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // d2s 0x100 -> 0x40, 4 words, ack 3 cycles after request
        for (int unsigned i = 0; i < 4; i++) dram_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        lat_min = 3; lat_max = 3;
        run_cmd(2'b01, 32'h100, 32'h40, 10'd4, -1);
        for (int unsigned i = 0; i < 4; i++)
            check_eq("sram_content", 64'(sram_peek(32'h40 + 32'(4 * i))), 64'(32'hA0 + 32'(i)));

        // s2d single word, ack after 1 cycle
        sram_mem[32'h8] = 32'hDEADBEEF;
        lat_min = 1; lat_max = 1;
        run_cmd(2'b10, 32'h8, 32'h2000, 10'd1, -1);
        check_eq("dram_content", 64'(dram_peek(32'h2000)), 64'h0000_0000_DEAD_BEEF);

        // zero width: completion two cycles after the command
        run_cmd(2'b01, 32'h500, 32'h600, 10'd0, 2);

        // reserved command in IDLE
        @(negedge clk);
        bus.dmaCmd = 2'b11; bus.dmaWidth = 10'd3;
        @(negedge clk);
        bus.dmaCmd = 2'b00;
        idle_busy = 0;
        repeat (6) begin
            #2;
            if (bus.stall || bus.dramReq || bus.sramWe) idle_busy++;
            @(negedge clk);
        end
        check_eq("cmd11_idle", 64'(idle_busy), 64'd0);

        // misaligned source
        run_cmd(2'b01, 32'h102, 32'h40, 10'd2, -1);
        @(negedge clk); #2;
`ifdef DMA_ALIGN_CHECK_EN
        check_eq("err_hold", 64'(bus.dmaErr), 64'd1);
`else
        check_eq("err_hold", 64'(bus.dmaErr), 64'd0);
`endif
        lat_min = 0; lat_max = 2;
        run_cmd(2'b10, 32'h20, 32'h3000, 10'd2, -1);
        @(negedge clk); #2;
        check_eq("err_cleared", 64'(bus.dmaErr), 64'd0);

        // reset during word 2 of 4 with the DRAM request held
        lat_min = 3; lat_max = 3;
        push_expected(2'b01, 32'h300, 32'h80, 10'd4);
        @(negedge clk);
        bus.dmaCmd = 2'b01; bus.dmaSrcAddress = 32'h300; bus.dmaDstAddress = 32'h80; bus.dmaWidth = 10'd4;
        @(negedge clk);
        bus.dmaCmd = 2'b00;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            #2;
            if (bus.dramReq && !bus.dramWe && bus.dramAddress == 32'h304 && !bus.dramAck) found = 1;
            else @(negedge clk);
        end
        check_eq("mid_req_reached", 64'(found), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("midreset_ctrl", 64'({bus.stall, bus.dmaValid, bus.dmaErr, bus.dramReq, bus.dramWe, bus.sramWe}), 64'd0);
        check_eq("midreset_bus", 64'(bus.dramAddress | bus.dramWriteData | bus.sramAddress | bus.sramWriteData), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle_busy = 0;
        repeat (6) begin
            #2;
            if (bus.stall || bus.dmaValid) idle_busy++;
            @(negedge clk);
        end
        check_eq("post_reset_idle", 64'(idle_busy), 64'd0);
        run_cmd(2'b01, 32'h300, 32'h80, 10'd4, -1);

        // address wrap and maximum width
        lat_min = 0; lat_max = 2;
        run_cmd(2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 10'd3, -1);
        lat_min = 0; lat_max = 0;
        run_cmd(2'b01, 32'h0001_0000, 32'h0002_0000, 10'd1023, -1);

        // randomized commands
        lat_min = 0; lat_max = 3;
        for (int unsigned i = 0; i < 14; i++) begin
            c = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
            s = $urandom & 32'h0000_FFFF;
            d = $urandom & 32'h0000_FFFF;
            if ($urandom_range(3, 0) != 0) begin
                s[1:0] = 2'b00;
                d[1:0] = 2'b00;
            end
            w = 10'($urandom_range(6, 0));
            run_cmd(c, s, d, w, -1);
        end

        repeat (5) @(negedge clk);
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
